if_id_skid_reg: RTL
===================

# if_id_skid_reg

Parametrised, elastic successor to the IF/ID pipeline register. It sits between instruction fetch and decode and carries an instruction word plus sideband such as the PC. It uses a valid/ready handshake with a two-entry skid buffer, so a decode stall never drops a fetched word and the upstream ready path is fully registered. Flush converts all held entries to bubbles: output NOP, valid low. A saturating counter reports how many valid entries flushes have discarded.

## Interface
- DATA_W, 32: instruction payload width; forced to NOP_VALUE when output is invalid
- SIDE_W, 32: sideband width (PC); passed unmasked
- NOP_VALUE, 32'h0000_0013: payload presented whenever o_valid is low
- CNT_W, 8: width of the flush-discard counter
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  branch/jump redirect; kills all held entries
- i_stall  in  1  hazard stall from decode; treated as downstream not-ready
- i_valid  in  1  upstream word valid
- i_data  in  DATA_W  upstream instruction
- i_side  in  SIDE_W  upstream PC/sideband
- o_ready  out  1  upstream may transfer this cycle
- o_valid  out  1  output word valid
- o_data  out  DATA_W  instruction to decode
- o_side  out  SIDE_W  PC/sideband to decode
- i_ready  in  1  downstream accepts
- o_level  out  2  occupied entries, 0..2
- o_flush_cnt  out  CNT_W  saturating count of discarded valid entries

## Operation
- Storage consists of a main entry M {mv, md, ms}, which drives the outputs, and a skid entry S {sv, sd, ss}.
- Derived terms:
  - rdy = i_ready & ~i_stall
  - in_fire = i_valid & o_ready & ~i_flush
  - out_fire = o_valid & rdy
- Outputs:
  - o_ready = ~sv & ~i_reset
  - o_valid = mv & ~i_flush
  - o_data = o_valid ? md : NOP_VALUE
  - o_side = ms
  - o_level = mv + sv
- Next state when i_flush = 1: mv <= 0 and sv <= 0. Input is not captured. The counter adds mv + sv, saturating at all-ones.
- Next state when i_flush = 0 and sv = 1:
  - If rdy: M <= S and sv <= 0.
  - Otherwise hold both entries.
  - No input is accepted, because o_ready = 0.
- Next state when i_flush = 0, sv = 0, and (~mv | rdy): M <= input data and mv <= in_fire.
- Next state when i_flush = 0, sv = 0, mv = 1, and ~rdy: if in_fire, S <= input and sv <= 1. Otherwise hold.
- Data and sideband registers load only on the transfers listed above. Otherwise they hold their value.
- The counter never wraps. It holds at 2^CNT_W-1.

## Timing
- Reset (asynchronous) forces:
  - mv = 0, sv = 0, md = sd = NOP_VALUE, ms = ss = 0, counter = 0.
  - Outputs: o_valid = 0, o_data = NOP_VALUE, o_side = 0, o_level = 0, o_flush_cnt = 0, o_ready = 0 while reset is held.
- First cycle after reset release: o_ready = 1.
- Latency is 1 cycle from in_fire to o_valid. Throughput is 1 word/cycle when rdy is continuously high.
- o_ready depends only on registered state and i_reset, with no combinational path from i_ready or i_stall.
- o_valid and o_data depend combinationally on i_flush. A same-cycle flush shows NOP immediately.
- Flush coinciding with i_valid: the word is dropped and not counted, because it was never held.
- Flush coinciding with a stall: flush wins, and both entries clear.
- Full (sv = 1) with rdy: the skid word moves to M next cycle and o_ready returns to 1 in that same cycle.
- A stall lasting N cycles loses no data. At most 2 words are buffered.
- Reset asserted mid-transfer: all entries are discarded without counting.

## Test plan
- Reset/idle: hold i_reset for 3 cycles, then release -> o_valid=0, o_data=0x00000013, o_ready=0 during reset and 1 after release, o_level=0, o_flush_cnt=0.
- Streaming: send 0x00A00093/PC 0x0, 0x00100113/PC 0x4, and 0x002081B3/PC 0x8 on consecutive cycles with i_ready=1 -> each appears on o_data/o_side exactly 1 cycle later, back-to-back, with o_level=1.
- Stall fill: stream words A, B, C and raise i_stall after A is captured -> A holds on the output, B goes to skid, o_ready=0, o_level=2, and C is held upstream. Drop the stall -> A, B, C emerge in order with none lost or duplicated.
- Flush while full: with o_level=2, pulse i_flush for 1 cycle -> o_valid=0 and o_data=NOP in that cycle, o_level=0 next cycle, o_flush_cnt increments by 2, and the i_valid word presented in the flush cycle never appears.
- Counter saturation: with CNT_W=2, perform four flushes each discarding 1 entry -> o_flush_cnt goes 1, 2, 3, 3.
- Async reset mid-stall: assert i_reset between clock edges while o_level=2 -> outputs go to reset values immediately, before the next edge, and o_flush_cnt=0.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid register.
// The slave modport is the register's view; master is the fetch/decode side driving it.
interface if_id_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int SIDE_W = 32,
  parameter int CNT_W  = 8
);
  logic              i_flush;
  logic              i_stall;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic [SIDE_W-1:0] i_side;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [SIDE_W-1:0] o_side;
  logic              i_ready;
  logic [1:0]        o_level;
  logic [CNT_W-1:0]  o_flush_cnt;

  modport slave (
    input  i_flush, i_stall, i_valid, i_data, i_side, i_ready,
    output o_ready, o_valid, o_data, o_side, o_level, o_flush_cnt
  );

  modport master (
    output i_flush, i_stall, i_valid, i_data, i_side, i_ready,
    input  o_ready, o_valid, o_data, o_side, o_level, o_flush_cnt
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID register: main entry drives decode, skid entry absorbs the word
// already in flight when decode stalls, so o_ready comes straight from a flop.
module if_id_skid_reg #(
  parameter int          DATA_W    = 32,
  parameter int          SIDE_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = 32'h0000_0013,
  parameter int          CNT_W     = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  if_id_skid_reg_if.slave bus
);
  logic              r_mv, r_sv;
  logic [DATA_W-1:0] r_md, r_sd;
  logic [SIDE_W-1:0] r_ms, r_ss;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rdy;
  logic              w_in_fire;
  logic [CNT_W:0]    w_cnt_sum;

  assign w_rdy     = bus.i_ready & ~bus.i_stall;
  assign w_in_fire = bus.i_valid & bus.o_ready & ~bus.i_flush;
  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(r_mv) + (CNT_W+1)'(r_sv);

  assign bus.o_ready     = ~r_sv & ~i_reset;
  assign bus.o_valid     = r_mv & ~bus.i_flush;
  assign bus.o_data      = bus.o_valid ? r_md : NOP_VALUE;
  assign bus.o_side      = r_ms;
  assign bus.o_level     = {1'b0, r_mv} + {1'b0, r_sv};
  assign bus.o_flush_cnt = r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mv  <= 1'b0;
      r_sv  <= 1'b0;
      r_md  <= NOP_VALUE;
      r_sd  <= NOP_VALUE;
      r_ms  <= '0;
      r_ss  <= '0;
      r_cnt <= '0;
    end else if (bus.i_flush) begin
      // Only entries actually held count as discarded; the carry bit saturates.
      r_mv  <= 1'b0;
      r_sv  <= 1'b0;
      r_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end else if (r_sv) begin
      if (w_rdy) begin
        r_mv <= 1'b1;
        r_md <= r_sd;
        r_ms <= r_ss;
        r_sv <= 1'b0;
      end
    end else if (~r_mv | w_rdy) begin
      r_mv <= w_in_fire;
      if (w_in_fire) begin
        r_md <= bus.i_data;
        r_ms <= bus.i_side;
      end
    end else if (w_in_fire) begin
      r_sv <= 1'b1;
      r_sd <= bus.i_data;
      r_ss <= bus.i_side;
    end
  end
endmodule
